// File: rtl/alux_pkg.sv
// Shared encodings and size helpers for the repeat shift/rotate unit.
package alux_pkg;

    // Operation encodings
    localparam logic [1:0] OP_RRC = 2'b00;
    localparam logic [1:0] OP_RRA = 2'b01;
    localparam logic [1:0] OP_RLA = 2'b10;
    localparam logic [1:0] OP_RRU = 2'b11;

    // Operand size encodings (2'b11 is reserved and behaves as word)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_ADDR = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Index of the active MSB for a given size; data_w is the address-word width.
    function automatic int unsigned size_msb(input logic [1:0] sz, input int unsigned data_w);
        int unsigned m;
        case (sz)
            SZ_BYTE: m = 32'd7;
            SZ_ADDR: m = data_w - 32'd1;
            default: m = 32'd15;
        endcase
        return m;
    endfunction

    // Mask of the active bits for a given size (widths up to 32 bits).
    function automatic logic [31:0] size_mask(input logic [1:0] sz, input int unsigned data_w);
        logic [31:0] m;
        case (sz)
            SZ_BYTE: m = 32'h0000_00FF;
            SZ_ADDR: begin
                if (data_w >= 32'd32) begin
                    m = 32'hFFFF_FFFF;
                end else begin
                    m = (32'd1 << data_w) - 32'd1;
                end
            end
            default: m = 32'h0000_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alux_shift_step.sv
// Combinational single-bit shift/rotate step on a size-masked operand.
module alux_shift_step
    import alux_pkg::*;
#(
    parameter int unsigned DATA_W = 20
) (
    input  logic [DATA_W-1:0] x,
    input  logic              c,
    input  logic [1:0]        op,
    input  logic [1:0]        size,
    output logic [DATA_W-1:0] x_next,
    output logic              c_next
);

    localparam int unsigned IDX_W = $clog2(DATA_W);

    logic [IDX_W-1:0]  msb_s;
    logic [DATA_W-1:0] mask_s;
    logic [DATA_W-1:0] top_s;
    logic [DATA_W-1:0] raw_s;

    assign msb_s  = IDX_W'(size_msb(size, DATA_W));
    assign mask_s = DATA_W'(size_mask(size, DATA_W));
    assign top_s  = DATA_W'(1'b1) << msb_s;

    // Select the bit entering at the active MSB (or LSB for RLA) and the bit leaving.
    always_comb begin
        raw_s  = x;
        c_next = c;
        case (op)
            OP_RRC: begin
                c_next = x[0];
                raw_s  = (x >> 1'b1) | (c ? top_s : {DATA_W{1'b0}});
            end
            OP_RRA: begin
                c_next = x[0];
                raw_s  = (x >> 1'b1) | (x[msb_s] ? top_s : {DATA_W{1'b0}});
            end
            OP_RLA: begin
                c_next = x[msb_s];
                raw_s  = x << 1'b1;
            end
            OP_RRU: begin
                c_next = x[0];
                raw_s  = x >> 1'b1;
            end
            default: begin
                c_next = c;
                raw_s  = x;
            end
        endcase
    end

    // Bits above the active MSB are always forced to zero.
    assign x_next = raw_s & mask_s;

endmodule

// File: rtl/alux_repeat_shifter.sv
// Multi-cycle repeat shift/rotate unit: one single-bit step per clock for
// count_m1+1 steps, with registered result and flags held until the next op.
module alux_repeat_shifter
    import alux_pkg::*;
#(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [1:0]        size,
    input  logic [CNT_W-1:0]  count_m1,
    input  logic [DATA_W-1:0] src,
    input  logic              Cin,
    input  logic              Vin,
    input  logic              Nin,
    input  logic              Zin,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              Cout,
    output logic              Vout,
    output logic              Nout,
    output logic              Zout
);

    localparam int unsigned IDX_W = $clog2(DATA_W);

    state_t            state_r;
    state_t            next_state_s;

    logic [DATA_W-1:0] x_r;
    logic              c_r;
    logic [1:0]        op_r;
    logic [1:0]        size_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [DATA_W-1:0] x_next_s;
    logic              c_next_s;
    logic [DATA_W-1:0] load_mask_s;
    logic [IDX_W-1:0]  msb_r_s;

    logic              load_s;
    logic              step_s;
    logic              finish_s;

    logic              busy_r;
    logic              done_r;
    logic [DATA_W-1:0] result_r;
    logic              cout_r;
    logic              vout_r;
    logic              nout_r;
    logic              zout_r;

    // V/N/Z inputs exist only for symmetry with the ALU interface.
    logic              unused_flags_s;
    assign unused_flags_s = Vin ^ Nin ^ Zin;

    assign load_mask_s = DATA_W'(size_mask(size, DATA_W));
    assign msb_r_s     = IDX_W'(size_msb(size_r, DATA_W));

    alux_shift_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .x      (x_r),
        .c      (c_r),
        .op     (op_r),
        .size   (size_r),
        .x_next (x_next_s),
        .c_next (c_next_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: leave SHIFT on the edge that performs the last step.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_SHIFT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output/control decode: load on accepted start, step while shifting.
    always_comb begin
        load_s   = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s = start;
            end
            ST_SHIFT: begin
                step_s   = 1'b1;
                finish_s = (cnt_r == {CNT_W{1'b0}});
            end
            default: begin
                load_s   = 1'b0;
                step_s   = 1'b0;
                finish_s = 1'b0;
            end
        endcase
    end

    // Working operand, carry and remaining-step counter (remaining minus one).
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r    <= {DATA_W{1'b0}};
            c_r    <= 1'b0;
            op_r   <= OP_RRC;
            size_r <= SZ_BYTE;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (load_s) begin
            x_r    <= src & load_mask_s;
            c_r    <= Cin;
            op_r   <= op;
            size_r <= size;
            cnt_r  <= count_m1;
        end else if (step_s) begin
            x_r    <= x_next_s;
            c_r    <= c_next_s;
            cnt_r  <= cnt_r - CNT_W'(1'b1);
        end else begin
            x_r    <= x_r;
            c_r    <= c_r;
            cnt_r  <= cnt_r;
        end
    end

    // Registered outputs; result and flags update only on the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {DATA_W{1'b0}};
            cout_r   <= 1'b0;
            vout_r   <= 1'b0;
            nout_r   <= 1'b0;
            zout_r   <= 1'b0;
        end else begin
            busy_r <= (next_state_s == ST_SHIFT);
            done_r <= finish_s;
            vout_r <= 1'b0;
            if (finish_s) begin
                result_r <= x_next_s;
                cout_r   <= c_next_s;
                nout_r   <= x_next_s[msb_r_s];
                zout_r   <= (x_next_s == {DATA_W{1'b0}});
            end else begin
                result_r <= result_r;
                cout_r   <= cout_r;
                nout_r   <= nout_r;
                zout_r   <= zout_r;
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign Cout   = cout_r;
    assign Vout   = vout_r;
    assign Nout   = nout_r;
    assign Zout   = zout_r;

endmodule

// File: tb/tb_alux_repeat_shifter.sv
// Directed self-checking bench for alux_repeat_shifter.
module tb_alux_repeat_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [1:0]  size;
    logic [3:0]  count_m1;
    logic [19:0] src;
    logic        Cin, Vin, Nin, Zin;
    logic        busy, done;
    logic [19:0] result;
    logic        Cout, Vout, Nout, Zout;

    int checks_cnt;
    int fail_cnt;

    alux_repeat_shifter #(.DATA_W(20), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .size     (size),
        .count_m1 (count_m1),
        .src      (src),
        .Cin      (Cin),
        .Vin      (Vin),
        .Nin      (Nin),
        .Zin      (Zin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .Cout     (Cout),
        .Vout     (Vout),
        .Nout     (Nout),
        .Zout     (Zout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one op at a negedge, then wait (bounded) for done and check everything.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [1:0] s,
                          input logic [3:0] cm1, input logic [19:0] sv, input logic ci,
                          input logic [19:0] exp_res, input logic ec, input logic en,
                          input logic ez);
        int k;
        @(negedge clk);
        op = o; size = s; count_m1 = cm1; src = sv; Cin = ci;
        Vin = 1'b1; Nin = 1'b1; Zin = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd1);
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "_lat"}, k, 32'(cm1) + 32'd1);
        check_val({tag, "_res"}, {12'd0, result}, {12'd0, exp_res});
        check_val({tag, "_c"}, {31'd0, Cout}, {31'd0, ec});
        check_val({tag, "_n"}, {31'd0, Nout}, {31'd0, en});
        check_val({tag, "_z"}, {31'd0, Zout}, {31'd0, ez});
        check_val({tag, "_v"}, {31'd0, Vout}, 32'd0);
        check_val({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int k;
        int dones;
        checks_cnt = 0;
        fail_cnt   = 0;
        rst = 1'b1; start = 1'b0; op = 2'b00; size = 2'b00; count_m1 = 4'd0;
        src = 20'h0; Cin = 1'b0; Vin = 1'b0; Nin = 1'b0; Zin = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_res", {12'd0, result}, 32'd0);
        check_val("rst_flags", {28'd0, Cout, Vout, Nout, Zout}, 32'd0);
        rst = 1'b0;

        //          tag       op     size   cm1   src        Cin   result    C     N     Z
        run_op("rra_w",   2'b01, 2'b01, 4'd1,  20'h08004, 1'b0, 20'h0E001, 1'b0, 1'b1, 1'b0);
        run_op("rla_b",   2'b10, 2'b00, 4'd0,  20'hFFF81, 1'b0, 20'h00002, 1'b1, 1'b0, 1'b0);
        run_op("rrc_a",   2'b00, 2'b10, 4'd0,  20'h00001, 1'b1, 20'h80000, 1'b1, 1'b1, 1'b0);
        run_op("rru_w16", 2'b11, 2'b01, 4'd15, 20'h00001, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b1);
        run_op("rrc_b2",  2'b00, 2'b00, 4'd1,  20'h00001, 1'b0, 20'h00080, 1'b0, 1'b1, 1'b0);
        run_op("rra_rsv", 2'b01, 2'b11, 4'd0,  20'h18000, 1'b1, 20'h0C000, 1'b0, 1'b1, 1'b0);
        run_op("rla_a",   2'b10, 2'b10, 4'd0,  20'h80000, 1'b0, 20'h00000, 1'b1, 1'b0, 1'b1);
        run_op("rra_b4",  2'b01, 2'b00, 4'd3,  20'hFFF80, 1'b0, 20'h000F8, 1'b0, 1'b1, 1'b0);

        // Reset mid-operation with an ignored second start.
        @(negedge clk);
        op = 2'b00; size = 2'b01; count_m1 = 4'd7; src = 20'h01234; Cin = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op = 2'b10; size = 2'b00; count_m1 = 4'd0; src = 20'h000FF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("ign_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mrst_busy", {31'd0, busy}, 32'd0);
        check_val("mrst_done", {31'd0, done}, 32'd0);
        check_val("mrst_res", {12'd0, result}, 32'd0);
        check_val("mrst_flags", {28'd0, Cout, Vout, Nout, Zout}, 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_val("mrst_no_done", dones, 32'd0);

        // Back-to-back: second start held high in the first done cycle.
        @(negedge clk);
        op = 2'b10; size = 2'b00; count_m1 = 4'd0; src = 20'h00081; Cin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_val("b2b1_lat", k, 32'd1);
        check_val("b2b1_res", {12'd0, result}, 32'h00002);
        op = 2'b11; size = 2'b01; count_m1 = 4'd1; src = 20'h00004;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("b2b2_busy", {31'd0, busy}, 32'd1);
        check_val("b2b2_done_low", {31'd0, done}, 32'd0);
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_val("b2b2_lat", k, 32'd2);
        check_val("b2b2_res", {12'd0, result}, 32'h00001);
        check_val("b2b2_c", {31'd0, Cout}, 32'd0);
        check_val("b2b2_z", {31'd0, Zout}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
